// File: rtl/aq_djpeg_mcu_buffer.sv
// Double-banked MCU sample buffer between the IDCT and the YCbCr->RGB converter.
// Optional status outputs are enabled with `define AQ_DJPEG_MCUBUF_STATUS_EN.
module aq_djpeg_mcu_buffer #(
    parameter int unsigned DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          WrEnable,
    output logic          WrReady,
    input  logic [2:0]    WrBlock,
    input  logic [5:0]    WrAddr,
    input  logic [DW-1:0] WrData,
    input  logic [11:0]   WrBlockX,
    input  logic [11:0]   WrBlockY,
    input  logic [2:0]    WrComp,
    output logic          OutEnable,
    input  logic          InRead,
    input  logic [7:0]    InAddress,
    output logic [11:0]   OutBlockX,
    output logic [11:0]   OutBlockY,
    output logic [2:0]    OutComp,
    output logic [DW-1:0] OutY,
    output logic [DW-1:0] OutCb,
    output logic [DW-1:0] OutCr
`ifdef AQ_DJPEG_MCUBUF_STATUS_EN
    ,
    output logic          StatOverflow,
    output logic          StatUnderrun,
    output logic [15:0]   StatMcuCount
`endif
);

    typedef enum logic [0:0] {StIdle, StReading} rd_state_e;

    rd_state_e     rd_state_q, rd_state_d;
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [2:0]    blk_cnt_q, blk_cnt_d;
    logic [5:0]    smp_cnt_q, smp_cnt_d;
    logic [11:0]   bx_q [2];
    logic [11:0]   by_q [2];
    logic [2:0]    comp_q [2];
    logic [DW-1:0] out_y_q, out_cb_q, out_cr_q;

    logic [DW-1:0] y_mem  [512];
    logic [DW-1:0] cb_mem [128];
    logic [DW-1:0] cr_mem [128];

    logic       reading, wr_acc, wr_first, blk_last, mcu_done, rd_ok, rd_release, rd_comp3;
    logic [2:0] wr_comp_eff, blk_cnt_inc;
    logic [8:0] y_waddr, y_raddr;
    logic [6:0] c_waddr, c_raddr;

    assign reading     = (rd_state_q == StReading);
    assign WrReady     = !full_q[wr_bank_q];
    assign OutEnable   = full_q[rd_bank_q] && !reading;
    assign wr_acc      = WrEnable && WrReady;
    assign wr_first    = (blk_cnt_q == 3'd0) && (smp_cnt_q == 6'd0);
    // The first sample's component count is not in the metadata register yet.
    assign wr_comp_eff = wr_first ? WrComp : comp_q[wr_bank_q];
    assign blk_cnt_inc = blk_cnt_q + 3'd1;
    assign blk_last    = wr_acc && (WrAddr == 6'd63);
    assign mcu_done    = blk_last && (blk_cnt_inc == ((wr_comp_eff == 3'd3) ? 3'd6 : 3'd4));
    assign rd_ok       = InRead && (reading || full_q[rd_bank_q]);
    assign rd_release  = reading && InRead && (InAddress == 8'hFF);
    assign rd_comp3    = (comp_q[rd_bank_q] == 3'd3);

    assign y_waddr = {wr_bank_q, WrBlock[1], WrAddr[5:3], WrBlock[0], WrAddr[2:0]};
    assign c_waddr = {wr_bank_q, WrAddr};
    assign y_raddr = {rd_bank_q, InAddress};
    assign c_raddr = {rd_bank_q, InAddress[7:5], InAddress[3:1]};

    assign OutBlockX = bx_q[rd_bank_q];
    assign OutBlockY = by_q[rd_bank_q];
    assign OutComp   = comp_q[rd_bank_q];
    assign OutY      = out_y_q;
    assign OutCb     = out_cb_q;
    assign OutCr     = out_cr_q;

    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        blk_cnt_d  = blk_cnt_q;
        smp_cnt_d  = smp_cnt_q;
        rd_state_d = rd_state_q;
        if (wr_acc) begin
            smp_cnt_d = blk_last ? 6'd0 : smp_cnt_q + 6'd1;
            if (blk_last) begin
                blk_cnt_d = blk_cnt_inc;
            end
            if (mcu_done) begin
                blk_cnt_d         = 3'd0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        unique case (rd_state_q)
            StIdle: begin
                if (InRead && full_q[rd_bank_q]) begin
                    rd_state_d = StReading;
                end
            end
            StReading: begin
                if (rd_release) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    rd_state_d        = StIdle;
                end
            end
            default: rd_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= StIdle;
            full_q     <= 2'b00;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            blk_cnt_q  <= 3'd0;
            smp_cnt_q  <= 6'd0;
            bx_q[0]    <= 12'd0;
            bx_q[1]    <= 12'd0;
            by_q[0]    <= 12'd0;
            by_q[1]    <= 12'd0;
            comp_q[0]  <= 3'd0;
            comp_q[1]  <= 3'd0;
            out_y_q    <= '0;
            out_cb_q   <= '0;
            out_cr_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            blk_cnt_q  <= blk_cnt_d;
            smp_cnt_q  <= smp_cnt_d;
            if (wr_acc && wr_first) begin
                bx_q[wr_bank_q]   <= WrBlockX;
                by_q[wr_bank_q]   <= WrBlockY;
                comp_q[wr_bank_q] <= WrComp;
            end
            if (rd_ok) begin
                out_y_q  <= y_mem[y_raddr];
                out_cb_q <= rd_comp3 ? cb_mem[c_raddr] : '0;
                out_cr_q <= rd_comp3 ? cr_mem[c_raddr] : '0;
            end
        end
    end

    // Sample storage has no reset; contents of an empty bank are don't-care.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (!WrBlock[2]) begin
                y_mem[y_waddr] <= WrData;
            end else if (WrBlock == 3'd4) begin
                cb_mem[c_waddr] <= WrData;
            end else if (WrBlock == 3'd5) begin
                cr_mem[c_waddr] <= WrData;
            end
        end
    end

`ifdef AQ_DJPEG_MCUBUF_STATUS_EN
    logic        ovf_q, unr_q;
    logic [15:0] mcu_cnt_q;

    assign StatOverflow = ovf_q;
    assign StatUnderrun = unr_q;
    assign StatMcuCount = mcu_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            unr_q     <= 1'b0;
            mcu_cnt_q <= 16'd0;
        end else begin
            if (WrEnable && !WrReady) begin
                ovf_q <= 1'b1;
            end
            if (InRead && !reading && !OutEnable) begin
                unr_q <= 1'b1;
            end
            if (rd_release) begin
                mcu_cnt_q <= mcu_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_aq_djpeg_mcu_buffer.sv
// Randomized bench for aq_djpeg_mcu_buffer against a pixel-level FIFO-of-MCUs model.
module tb_aq_djpeg_mcu_buffer;
    localparam int DW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          WrEnable, WrReady, OutEnable, InRead;
    logic [2:0]    WrBlock, WrComp, OutComp;
    logic [5:0]    WrAddr;
    logic [DW-1:0] WrData, OutY, OutCb, OutCr;
    logic [11:0]   WrBlockX, WrBlockY, OutBlockX, OutBlockY;
    logic [7:0]    InAddress;
`ifdef AQ_DJPEG_MCUBUF_STATUS_EN
    logic          StatOverflow, StatUnderrun;
    logic [15:0]   StatMcuCount;
`endif

    always #5 clk = ~clk;

    aq_djpeg_mcu_buffer #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .WrEnable(WrEnable), .WrReady(WrReady), .WrBlock(WrBlock), .WrAddr(WrAddr),
        .WrData(WrData), .WrBlockX(WrBlockX), .WrBlockY(WrBlockY), .WrComp(WrComp),
        .OutEnable(OutEnable), .InRead(InRead), .InAddress(InAddress),
        .OutBlockX(OutBlockX), .OutBlockY(OutBlockY), .OutComp(OutComp),
        .OutY(OutY), .OutCb(OutCb), .OutCr(OutCr)
`ifdef AQ_DJPEG_MCUBUF_STATUS_EN
        , .StatOverflow(StatOverflow), .StatUnderrun(StatUnderrun), .StatMcuCount(StatMcuCount)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: up to two complete MCUs queued, stored as expected per-pixel output.
    logic [8:0]  m_y [2][256];
    logic [8:0]  m_cb[2][256];
    logic [8:0]  m_cr[2][256];
    logic [11:0] m_bx[2], m_by[2];
    logic [2:0]  m_comp[2];
    bit          m_pat[2];
    int          m_head, m_count;
    bit          m_reading;
    logic [8:0]  e_y, e_cb, e_cr;
    bit          m_ovf, m_unr;
    int          m_mcus;

    // Writer and reader agents.
    bit          w_go, w_active, w_rand, w_pattern, w_pat, w_hold;
    int          w_left, w_blk, w_addr, w_nblk, w_pct;
    logic [2:0]  w_comp, w_fix_comp;
    logic [11:0] w_bx, w_by, w_fix_bx;
    bit          r_go, r_active, r_hold;
    int          r_addr, r_pct;

    function automatic logic [8:0] sample_val(input int b, input int a);
        if (!w_pat) return 9'($urandom);
        if (b == 4) return 9'd100;
        if (b == 5) return 9'h19C;  // -100
        return 9'(b * 64 + a);
    endfunction

    task automatic model_reset();
        m_head = 0; m_count = 0; m_reading = 0;
        e_y = '0; e_cb = '0; e_cr = '0;
        m_ovf = 0; m_unr = 0; m_mcus = 0;
        w_active = 0; r_active = 0;
    endtask

    task automatic step();
        bit acc, rdok, rel, pre_reading;
        int w, hd, pre_count, x, y, pix;
        WrEnable = 1'b0;
        InRead   = 1'b0;
        WrData   = 9'($urandom);
        WrBlockX = 12'($urandom);
        WrBlockY = 12'($urandom);
        WrComp   = 3'($urandom);
        InAddress = 8'($urandom);
        if (!w_active && w_left > 0) begin
            w_active = 1; w_blk = 0; w_addr = 0; w_left--; w_pat = w_pattern;
            if (w_rand) begin
                w_comp = ($urandom_range(1) != 0) ? 3'd3 : 3'd1;
                w_bx = 12'($urandom); w_by = 12'($urandom);
            end else begin
                w_comp = w_fix_comp; w_bx = w_fix_bx; w_by = 12'd7;
                w_fix_bx = w_fix_bx + 12'd1;
            end
            w_nblk = (w_comp == 3'd3) ? 6 : 4;
        end
        if (w_active && w_go && $urandom_range(99) < w_pct &&
            !(w_hold && w_blk == w_nblk - 1 && w_addr == 63)) begin
            WrEnable = 1'b1; WrBlock = 3'(w_blk); WrAddr = 6'(w_addr);
            WrData = sample_val(w_blk, w_addr);
            if (w_blk == 0 && w_addr == 0) begin
                WrBlockX = w_bx; WrBlockY = w_by; WrComp = w_comp;
            end
        end
        if (r_go && !r_active && m_count > 0 && !m_reading) begin
            r_active = 1; r_addr = 0;
        end
        if (r_active && $urandom_range(99) < r_pct && !(r_hold && r_addr == 255)) begin
            InRead = 1'b1; InAddress = 8'(r_addr);
        end
        pre_count = m_count; pre_reading = m_reading; hd = m_head;
        acc  = WrEnable && m_count < 2;
        rdok = InRead && (m_reading || m_count > 0);
        rel  = InRead && m_reading && InAddress == 8'hFF;
        w    = (m_head + m_count) % 2;
        @(posedge clk);
        #1;
        if (WrEnable && pre_count == 2) m_ovf = 1;
        if (InRead && !pre_reading && pre_count == 0) m_unr = 1;
        if (acc) begin
            if (w_blk == 0 && w_addr == 0) begin
                m_bx[w] = WrBlockX; m_by[w] = WrBlockY; m_comp[w] = w_comp; m_pat[w] = w_pat;
                for (int i = 0; i < 256; i++) begin m_cb[w][i] = '0; m_cr[w][i] = '0; end
            end
            if (w_blk < 4) begin
                if (w_comp == 3'd3) begin
                    x = (w_blk % 2) * 8 + w_addr % 8; y = (w_blk / 2) * 8 + w_addr / 8;
                    pix = y * 16 + x;
                end else begin
                    x = w_blk * 8 + w_addr % 8; y = w_addr / 8;
                    pix = (x / 16) * 128 + y * 16 + x % 16;
                end
                m_y[w][pix] = WrData;
            end else begin
                for (int dy = 0; dy < 2; dy++)
                    for (int dx = 0; dx < 2; dx++) begin
                        pix = (2 * (w_addr / 8) + dy) * 16 + 2 * (w_addr % 8) + dx;
                        if (w_blk == 4) m_cb[w][pix] = WrData;
                        else m_cr[w][pix] = WrData;
                    end
            end
            w_addr++;
            if (w_addr == 64) begin w_addr = 0; w_blk++; end
            if (w_blk == w_nblk) begin w_active = 0; m_count++; end
        end
        if (rdok) begin
            e_y = m_y[hd][InAddress]; e_cb = m_cb[hd][InAddress]; e_cr = m_cr[hd][InAddress];
            if (m_pat[hd] && m_comp[hd] == 3'd3 && InAddress == 8'h11) check("pat_y11", OutY, 9'h009);
            if (m_pat[hd] && m_comp[hd] == 3'd3 && InAddress == 8'h88) check("pat_y88", OutY, 9'd192);
            if (m_pat[hd] && m_comp[hd] == 3'd3 && InAddress == 8'h37) check("pat_cr", OutCr, 9'h19C);
            if (m_pat[hd] && m_comp[hd] == 3'd1 && InAddress == 8'h80) check("pat_y80", OutY, 9'd128);
            if (r_active) r_addr++;
        end
        if (rel) begin
            m_head = 1 - m_head; m_count--; m_reading = 0; r_active = 0; m_mcus++;
        end else if (rdok) begin
            m_reading = 1;
        end
        check("wr_ready", WrReady, 32'(m_count < 2));
        check("out_enable", OutEnable, 32'(m_count > 0 && !m_reading));
        check("out_y", OutY, e_y);
        check("out_cb", OutCb, e_cb);
        check("out_cr", OutCr, e_cr);
        if (m_count > 0) begin
            check("out_bx", OutBlockX, m_bx[m_head]);
            check("out_by", OutBlockY, m_by[m_head]);
            check("out_comp", OutComp, m_comp[m_head]);
        end
`ifdef AQ_DJPEG_MCUBUF_STATUS_EN
        check("stat_ovf", StatOverflow, 32'(m_ovf));
        check("stat_unr", StatUnderrun, 32'(m_unr));
        check("stat_mcus", StatMcuCount, 32'(m_mcus & 16'hFFFF));
`endif
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int i;
        for (i = 0; i < limit && !(w_left == 0 && !w_active && m_count == 0 && !r_active); i++)
            step();
        check(tag, 32'(i < limit), 32'd1);
    endtask

    initial begin
        rst = 1'b1; WrEnable = 0; InRead = 0; WrBlock = 0; WrAddr = 0; WrData = 0;
        WrBlockX = 0; WrBlockY = 0; WrComp = 0; InAddress = 0;
        w_go = 1; w_rand = 0; w_pattern = 1; w_hold = 0; w_left = 0; w_pct = 100;
        w_fix_comp = 3'd3; w_fix_bx = 12'd5; r_go = 1; r_hold = 0; r_pct = 100;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_ready", WrReady, 1); check("rst_out_enable", OutEnable, 0);
        check("rst_out_y", OutY, 0); check("rst_out_cb", OutCb, 0); check("rst_out_cr", OutCr, 0);
        check("rst_bx", OutBlockX, 0); check("rst_by", OutBlockY, 0); check("rst_comp", OutComp, 0);
        @(negedge clk); rst = 1'b0;

        // Patterned 4:2:0 MCU, then patterned 1-component MCU.
        w_left = 1; wait_idle("pat_c3_done", 2000);
        w_fix_comp = 3'd1; w_left = 1; wait_idle("pat_c1_done", 2000);

        // Back-to-back fill with drops, then drain.
        w_pattern = 0; w_fix_comp = 3'd3; w_fix_bx = 12'd5; r_go = 0; w_left = 2;
        for (int i = 0; i < 2000 && m_count < 2; i++) step();
        check("b2b_full", 32'(m_count), 32'd2);
        w_left = 1;
        repeat (30) step();
        check("b2b_ready_low", WrReady, 0);
        r_go = 1; wait_idle("b2b_done", 3000);

        // Release and completion in the same cycle.
        w_left = 2; w_hold = 1; r_go = 0;
        for (int i = 0; i < 2000 && !(m_count == 1 && w_active && w_blk == w_nblk - 1 && w_addr == 63); i++)
            step();
        r_go = 1; r_hold = 1;
        for (int i = 0; i < 1000 && !(m_reading && r_addr == 255); i++) step();
        w_hold = 0; r_hold = 0;
        step();
        check("simul_oe", OutEnable, 1);
        check("simul_count", 32'(m_count), 32'd1);
        wait_idle("simul_done", 2000);

        // Random concurrent traffic.
        w_rand = 1; w_pct = 85; r_pct = 70; w_left = 12;
        wait_idle("rand_done", 30000);

        // Asynchronous reset mid-read at address 100.
        w_rand = 0; w_pct = 100; r_pct = 100; w_fix_bx = 12'd9; w_left = 1;
        for (int i = 0; i < 2000 && !(m_reading && r_addr == 100); i++) step();
        #2 rst = 1'b1;
        #1;
        check("arst_out_enable", OutEnable, 0); check("arst_wr_ready", WrReady, 1);
        check("arst_out_y", OutY, 0); check("arst_bx", OutBlockX, 0);
        model_reset(); w_left = 0;
        @(negedge clk); rst = 1'b0;
        w_left = 1; wait_idle("post_rst_done", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
